// File: rtl/i_mem_loader.sv
// rtl/i_mem_loader.sv - streams a program into the instruction BRAM, zero-fills the rest, holds the CPU meanwhile.
// Optional bracket balance checker: define I_MEM_LOADER_BRACKET_CHECK_EN.
module i_mem_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] TERM_BYTE = '0
) (
  input  logic                  clka,
  input  logic                  rsta,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  wea,
  output logic [ADDR_WIDTH-1:0] addra,
  output logic [DATA_WIDTH-1:0] dia,
  output logic                  cpu_hold,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   len,
  output logic                  bracket_err
);

  typedef enum logic [1:0] {IDLE, LOAD, CLEAR, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] ptr, ptr_n, addra_n;
  logic [DATA_WIDTH-1:0] dia_n;
  logic [ADDR_WIDTH:0]   len_n;
  logic                  in_ready_n, wea_n, cpu_hold_n, done_n;
  logic                  accept;

  assign accept = in_valid && in_ready;

`ifdef I_MEM_LOADER_BRACKET_CHECK_EN
  localparam logic [DATA_WIDTH-1:0] OPEN_BR  = DATA_WIDTH'(8'h5B);
  localparam logic [DATA_WIDTH-1:0] CLOSE_BR = DATA_WIDTH'(8'h5D);
  logic [ADDR_WIDTH:0] depth, depth_n;
  logic                berr_n;
`endif

  // Outputs are registered copies of the *_n values, so a write shows up the cycle after its byte is accepted.
  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    len_n      = len;
    addra_n    = addra;
    dia_n      = dia;
    wea_n      = 1'b0;
    done_n     = 1'b0;
    in_ready_n = 1'b0;
    cpu_hold_n = cpu_hold;
`ifdef I_MEM_LOADER_BRACKET_CHECK_EN
    depth_n    = depth;
    berr_n     = bracket_err;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          state_n    = LOAD;
          ptr_n      = '0;
          len_n      = '0;
          cpu_hold_n = 1'b1;
          in_ready_n = 1'b1;
`ifdef I_MEM_LOADER_BRACKET_CHECK_EN
          depth_n    = '0;
          berr_n     = 1'b0;
`endif
        end
      end
      LOAD: begin
        in_ready_n = 1'b1;
        if (accept) begin
          if (in_data == TERM_BYTE) begin
            state_n    = CLEAR;
            in_ready_n = 1'b0;
          end else begin
            wea_n   = 1'b1;
            addra_n = ptr;
            dia_n   = in_data;
            ptr_n   = ptr + 1'b1;
            len_n   = len + 1'b1;
`ifdef I_MEM_LOADER_BRACKET_CHECK_EN
            if (in_data == OPEN_BR) begin
              depth_n = depth + 1'b1;
            end else if (in_data == CLOSE_BR) begin
              if (depth == '0) berr_n = 1'b1;
              else             depth_n = depth - 1'b1;
            end
`endif
            if (ptr == LAST_ADDR) begin
              state_n    = DONE;
              in_ready_n = 1'b0;
            end
          end
        end
      end
      CLEAR: begin
        wea_n   = 1'b1;
        addra_n = ptr;
        dia_n   = '0;
        ptr_n   = ptr + 1'b1;
        if (ptr == LAST_ADDR) state_n = DONE;
      end
      DONE: begin
        done_n     = 1'b1;
        cpu_hold_n = 1'b0;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
`ifdef I_MEM_LOADER_BRACKET_CHECK_EN
    if (state_n == DONE && state != DONE && depth_n != '0) berr_n = 1'b1;
`endif
  end

  always_ff @(posedge clka) begin
    if (rsta) begin
      state    <= IDLE;
      ptr      <= '0;
      len      <= '0;
      addra    <= '0;
      dia      <= '0;
      wea      <= 1'b0;
      done     <= 1'b0;
      in_ready <= 1'b0;
      cpu_hold <= 1'b0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      len      <= len_n;
      addra    <= addra_n;
      dia      <= dia_n;
      wea      <= wea_n;
      done     <= done_n;
      in_ready <= in_ready_n;
      cpu_hold <= cpu_hold_n;
    end
  end

`ifdef I_MEM_LOADER_BRACKET_CHECK_EN
  always_ff @(posedge clka) begin
    if (rsta) begin
      depth       <= '0;
      bracket_err <= 1'b0;
    end else begin
      depth       <= depth_n;
      bracket_err <= berr_n;
    end
  end
`else
  assign bracket_err = 1'b0;
`endif

endmodule

// File: tb/tb_i_mem_loader.sv
// tb/tb_i_mem_loader.sv - directed table-driven bench for i_mem_loader.
module tb_i_mem_loader;
  localparam int DEPTH = 256;
`ifdef I_MEM_LOADER_BRACKET_CHECK_EN
  localparam bit BCHK = 1'b1;
`else
  localparam bit BCHK = 1'b0;
`endif

  logic       clka = 1'b0;
  logic       rsta, start, in_valid;
  logic [7:0] in_data;
  logic       in_ready, wea, cpu_hold, done, bracket_err;
  logic [7:0] addra, dia;
  logic [8:0] len;

  i_mem_loader dut (
    .clka(clka), .rsta(rsta), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .wea(wea), .addra(addra), .dia(dia), .cpu_hold(cpu_hold),
    .done(done), .len(len), .bracket_err(bracket_err)
  );

  always #5 clka = ~clka;

  int checks = 0;
  int failures = 0;
  logic [7:0] mem [DEPTH];
  int wcnt [DEPTH];
  int nwrites, done_cnt, overlap;

  // Memory model and event counters, sampled mid-cycle.
  always @(negedge clka) begin
    if (wea) begin
      mem[addra] = dia;
      wcnt[addra] = wcnt[addra] + 1;
      nwrites = nwrites + 1;
    end
    if (done) done_cnt = done_cnt + 1;
    if (wea && done) overlap = overlap + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clka);
    #1;
  endtask

  task automatic clear_counts();
    for (int i = 0; i < DEPTH; i++) wcnt[i] = 0;
    nwrites = 0;
    done_cnt = 0;
    overlap = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_wea"}, wea, 0);
    chk({tag, "_addra"}, addra, 0);
    chk({tag, "_dia"}, dia, 0);
    chk({tag, "_cpu_hold"}, cpu_hold, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_len"}, len, 0);
    chk({tag, "_bracket_err"}, bracket_err, 0);
  endtask

  typedef struct {
    logic [63:0] prog;
    int          n;
    bit          stall;
    int          exp_len;
    bit          exp_berr;
  } vec_t;

  vec_t vecs [8];

  function automatic logic [7:0] byte_at(input vec_t v, input int i);
    if (i < 8) return v.prog[63-8*i -: 8];
    return 8'h2B;
  endfunction

  task automatic run_vec(input int k);
    vec_t v;
    int idx, cyc, maxw, bad;
    logic [7:0] exp_b;
    v = vecs[k];
    clear_counts();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk($sformatf("v%0d_hold_on", k), cpu_hold, 1);
    chk($sformatf("v%0d_ready_on", k), in_ready, 1);
    idx = 0;
    cyc = 0;
    while (idx < v.n && cyc < 3000) begin
      in_data  = byte_at(v, idx);
      in_valid = v.stall ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (in_valid && in_ready) idx++;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    chk($sformatf("v%0d_fed", k), idx, v.n);
    chk($sformatf("v%0d_ready_drop", k), in_ready, 0);
    cyc = 0;
    while (done_cnt == 0 && cyc < 400) begin
      tick();
      cyc++;
    end
    tick();
    tick();
    chk($sformatf("v%0d_done_once", k), done_cnt, 1);
    chk($sformatf("v%0d_len", k), len, v.exp_len);
    chk($sformatf("v%0d_berr", k), bracket_err, BCHK ? v.exp_berr : 1'b0);
    chk($sformatf("v%0d_hold_off", k), cpu_hold, 0);
    chk($sformatf("v%0d_nwrites", k), nwrites, DEPTH);
    chk($sformatf("v%0d_overlap", k), overlap, 0);
    maxw = 0;
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (wcnt[i] > maxw) maxw = wcnt[i];
      exp_b = (i < v.exp_len) ? byte_at(v, i) : 8'h00;
      if (mem[i] !== exp_b) bad++;
    end
    chk($sformatf("v%0d_max_writes_per_addr", k), maxw, 1);
    chk($sformatf("v%0d_bad_image_bytes", k), bad, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{64'h2B5B2D5D00000000, 5,   1'b0, 4,   1'b0};
    vecs[1] = '{64'h2B2B2B2B2B2B2B2B, 256, 1'b0, 256, 1'b0};
    vecs[2] = '{64'h3E3C2E0000000000, 4,   1'b1, 3,   1'b0};
    vecs[3] = '{64'h0000000000000000, 1,   1'b0, 0,   1'b0};
    vecs[4] = '{64'h5B5B5D0000000000, 4,   1'b0, 3,   1'b1};
    vecs[5] = '{64'h5D5B000000000000, 3,   1'b0, 2,   1'b1};
    vecs[6] = '{64'h5B5D000000000000, 3,   1'b0, 2,   1'b0};
    vecs[7] = '{64'h5B5B5D5D00000000, 5,   1'b1, 4,   1'b0};

    rsta = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    clear_counts();
    repeat (3) tick();
    rsta = 1'b0;
    check_reset_outputs("reset");

    for (int k = 0; k < 8; k++) run_vec(k);

    // Start during LOAD is ignored; reset mid-load aborts and keeps written bytes.
    clear_counts();
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h2B;
    tick();
    in_data = 8'h3E;
    tick();
    in_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("abort_len_before_reset", len, 2);
    chk("abort_ready_after_start", in_ready, 1);
    chk("abort_hold_after_start", cpu_hold, 1);
    chk("abort_last_addr", addra, 1);
    rsta = 1'b1;
    tick();
    rsta = 1'b0;
    check_reset_outputs("abort");
    repeat (4) tick();
    chk("abort_mem0", mem[0], 8'h2B);
    chk("abort_mem1", mem[1], 8'h3E);
    chk("abort_nwrites", nwrites, 2);
    chk("abort_no_done", done_cnt, 0);

    run_vec(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
